// File: rtl/seq_divider_param.sv
// Purpose : parametrised restoring divider, signed (DIV) or unsigned (DIVU), with divide-by-zero reporting.
// Latency : done pulses WIDTH+1 edges after the accepting start edge; a zero divisor gives done after 1 edge.
// Backpressure: a start seen while busy is ignored; a start in the done cycle is accepted because the FSM is already idle.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   start, is_signed          : request and mode, sampled only when idle
//   dividend, divisor         : operands, captured with start
//   busy, done, div_by_zero   : status; done is a one-cycle pulse, div_by_zero holds until the next accepted start
//   quotient, remainder       : registered results (LO, HI)
//   result                    : {remainder, quotient} for a direct HI/LO load
module seq_divider_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic [2*WIDTH-1:0]   result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Upper WIDTH+1 bits: partial remainder; lower WIDTH bits: dividend shifting out, quotient shifting in.
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic [WIDTH-1:0]   dvd_abs, dvs_abs, q_mag, r_mag;
  logic [WIDTH:0]     sh_upper, sub_upper;
  logic [WIDTH-2:0]   sh_lower;
  logic               take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Shift left by one: the upper part picks up the next dividend bit.
    sh_upper  = work_q[2*WIDTH-1:WIDTH-1];
    sh_lower  = work_q[WIDTH-2:0];
    // The bit shifted out of the top only matters if it were ever set; it then implies a successful subtract.
    take      = work_q[2*WIDTH] | (sh_upper >= {1'b0, dvsr_q});
    sub_upper = sh_upper - {1'b0, dvsr_q};

    q_mag = work_q[WIDTH-1:0];
    r_mag = work_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dbz_d  = 1'b0;
          dvsr_d = dvs_abs;
          if (divisor == '0) begin
            // Keep the raw dividend so it can be returned uncorrected as the remainder.
            dz_d    = 1'b1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            work_d  = {{(WIDTH+1){1'b0}}, dividend};
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = is_signed & dividend[WIDTH-1];
            work_d  = {{(WIDTH+1){1'b0}}, dvd_abs};
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        work_d = {(take ? sub_upper : sh_upper), sh_lower, take};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          quot_d = '1;
          rem_d  = q_mag;
          dbz_d  = 1'b1;
        end else begin
          // Most-negative / -1 yields magnitude 2^(WIDTH-1) with a positive sign, i.e. the most-negative pattern.
          quot_d = q_neg_q ? -q_mag : q_mag;
          rem_d  = r_neg_q ? -r_mag : r_mag;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign result      = {rem_q, quot_q};

endmodule
